// File: rtl/icache_resp_if.sv
// ---------------------------------------------------------------------------
// icache_resp_if
// Bundles the fetch-side handshake and the memory-side refill port of the
// instruction cache.
//   Fetch side : read_flag/addr/flush in, read_data/busy/done out.
//   Memory side: mem_read/mem_addr out, mem_rdata/mem_done in.
// Modports:
//   slave  - the cache (icache_resp)
//   master - the environment: fetch stage plus memory arbiter
// ---------------------------------------------------------------------------
interface icache_resp_if;
    logic        read_flag;
    logic [31:0] addr;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        flush;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_done;

    modport slave (
        input  read_flag, addr, flush, mem_rdata, mem_done,
        output read_data, busy, done, mem_read, mem_addr
    );

    modport master (
        output read_flag, addr, flush, mem_rdata, mem_done,
        input  read_data, busy, done, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_resp.sv
// ---------------------------------------------------------------------------
// icache_resp
// Direct-mapped, read-only instruction cache. A hit answers one cycle after
// the request edge. A miss refills the whole line one word at a time,
// in ascending order, from the memory port, then answers.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - icache_resp_if.slave (fetch handshake + memory refill port)
// Parameters:
//   LINES - number of lines (power of two, >= 2)
//   WORDS - 32-bit words per line (power of two, >= 2)
// ---------------------------------------------------------------------------
module icache_resp #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    icache_resp_if.slave  bus
);
    localparam int INDEX_BITS = $clog2(LINES);
    localparam int OFF_BITS   = $clog2(WORDS);
    localparam int TAG_BITS   = 32 - 2 - OFF_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_RESP
    } state_e;

    // Request address fields, split straight off the fetch address
    logic [OFF_BITS-1:0]   in_off;
    logic [INDEX_BITS-1:0] in_idx;
    logic [TAG_BITS-1:0]   in_tag;

    assign in_off = bus.addr[OFF_BITS+1:2];
    assign in_idx = bus.addr[OFF_BITS+INDEX_BITS+1:OFF_BITS+2];
    assign in_tag = bus.addr[31:OFF_BITS+INDEX_BITS+2];

    // Registered state
    state_e                state_q,    state_d;
    logic [TAG_BITS-1:0]   req_tag_q,  req_tag_d;
    logic [INDEX_BITS-1:0] req_idx_q,  req_idx_d;
    logic [OFF_BITS-1:0]   req_off_q,  req_off_d;
    logic [OFF_BITS-1:0]   cnt_q,      cnt_d;
    logic [LINES-1:0]      valid_q,    valid_d;
    logic                  pend_q,     pend_d;
    logic [31:0]           read_data_q, read_data_d;

    // Line storage
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES][WORDS];

    logic                  data_we;
    logic                  tag_we;
    logic                  hit;

    logic                  busy_o;
    logic                  done_o;
    logic                  mem_read_o;
    logic [31:0]           mem_addr_o;

    // A flush sampled on the request edge invalidates everything first, so
    // the same-edge request must be treated as a miss.
    assign hit = valid_q[in_idx] && (tag_mem[in_idx] == in_tag) && !bus.flush;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned; that is what keeps this block latch-free.
        state_d     = state_q;
        req_tag_d   = req_tag_q;
        req_idx_d   = req_idx_q;
        req_off_d   = req_off_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        pend_d      = pend_q;
        read_data_d = read_data_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mem_read_o  = 1'b0;
        mem_addr_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end
                if (bus.read_flag) begin
                    req_tag_d = in_tag;
                    req_idx_d = in_idx;
                    req_off_d = in_off;
                    if (hit) begin
                        read_data_d = data_mem[in_idx][in_off];
                        state_d     = ST_RESP;
                    end else begin
                        // Line is invalid until its last word lands, so an
                        // aborted refill never leaves a half-filled line valid.
                        valid_d[in_idx] = 1'b0;
                        cnt_d           = '0;
                        state_d         = ST_REFILL;
                    end
                end
            end

            ST_REFILL: begin
                busy_o     = 1'b1;
                mem_read_o = 1'b1;
                // Concatenation, not addition: the top line wraps to
                // 0xFFFF_FFFC with no carry out of bit 31.
                mem_addr_o = {req_tag_q, req_idx_q, cnt_q, 2'b00};
                if (bus.flush) begin
                    pend_d = 1'b1;
                end
                if (bus.mem_done) begin
                    data_we = 1'b1;
                    if (cnt_q == req_off_q) begin
                        read_data_d = bus.mem_rdata;
                    end
                    cnt_d = cnt_q + 1'b1;
                    // WORDS is a power of two: all-ones is the last word
                    if (&cnt_q) begin
                        valid_d[req_idx_q] = 1'b1;
                        tag_we             = 1'b1;
                        state_d            = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
                // Deferred flush takes effect only after the response,
                // so the refilled data is delivered intact.
                if (pend_q || bus.flush) begin
                    valid_d = '0;
                end
                pend_d = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state: cleared asynchronously so mem_read/busy/done drop the
    // moment rst goes low, even mid-refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_off_q   <= '0;
            cnt_q       <= '0;
            valid_q     <= '0;
            pend_q      <= 1'b0;
            read_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of order.
            state_q     <= state_d;
            req_tag_q   <= req_tag_d;
            req_idx_q   <= req_idx_d;
            req_off_q   <= req_off_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
            read_data_q <= read_data_d;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; the valid bits
    // gate every use, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[req_idx_q][cnt_q] <= bus.mem_rdata;
        end
        if (tag_we) begin
            tag_mem[req_idx_q] <= req_tag_q;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.mem_read  = mem_read_o;
    assign bus.mem_addr  = mem_addr_o;

endmodule

// File: tb/tb_icache_resp.sv
// ---------------------------------------------------------------------------
// tb_icache_resp
// Self-checking bench for icache_resp. A memory responder answers refill
// requests with a configurable latency; a line-level reference model
// (which line base address each index holds) predicts hit/miss, refill
// address sequence and returned word for every fetch.
// ---------------------------------------------------------------------------
module tb_icache_resp;
    localparam int LINES      = 16;
    localparam int WORDS      = 4;
    localparam int LINE_BYTES = WORDS * 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    icache_resp_if bus ();

    logic resp_done  = 1'b0;
    logic stray_done = 1'b0;
    assign bus.mem_done = resp_done | stray_done;

    icache_resp #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- memory contents ----------------
    logic [31:0] mem_over [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    // ---------------- memory responder ----------------
    int          fixed_lat = 2;   // 0 selects a random latency 1..3 per word
    logic [31:0] addr_log [$];
    bit          req_open = 1'b0;
    int          lat_cnt  = 0;
    logic [31:0] cur_addr = '0;

    initial begin
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_done) begin
                resp_done = 1'b0;
                req_open  = 1'b0;
            end
            if (rst && bus.mem_read) begin
                if (!req_open) begin
                    req_open = 1'b1;
                    cur_addr = bus.mem_addr;
                    addr_log.push_back(cur_addr);
                    lat_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
                end else begin
                    check("mem_addr_stable", bus.mem_addr, cur_addr);
                end
                lat_cnt--;
                if (lat_cnt == 0) begin
                    resp_done     = 1'b1;
                    bus.mem_rdata = mem_word(cur_addr);
                end
            end else begin
                req_open = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    bit          m_valid [LINES];
    logic [31:0] m_base  [LINES];

    function automatic int line_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % LINES);
    endfunction

    task automatic model_flush();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // All driving and sampling by the main process happens at negedge.
    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_flush();
    endtask

    task automatic do_read(input logic [31:0] a, input bit flush_same, input bit flush_mid);
        logic [31:0] base;
        logic [31:0] exp;
        int          idx;
        bit          exp_hit;
        int          log_start;
        int          cyc;
        int          ndone;
        logic        prev_md;

        base = a & ~32'(LINE_BYTES - 1);
        exp  = mem_word(a & ~32'h3);
        idx  = line_of(a);
        if (flush_same) model_flush();
        exp_hit   = m_valid[idx] && (m_base[idx] == base);
        log_start = addr_log.size();

        bus.read_flag = 1'b1;
        bus.addr      = a;
        bus.flush     = flush_same;
        @(negedge clk);
        bus.read_flag = 1'b0;
        bus.flush     = 1'b0;

        if (exp_hit) begin
            check("hit_done", 32'(bus.done), 32'd1);
            check("hit_data", bus.read_data, exp);
            check("hit_busy", 32'(bus.busy), 32'd0);
            check("hit_mem_read", 32'(bus.mem_read), 32'd0);
        end else begin
            check("miss_busy", 32'(bus.busy), 32'd1);
            check("miss_done_early", 32'(bus.done), 32'd0);
            cyc     = 0;
            ndone   = 0;
            prev_md = 1'b0;
            while (!bus.done && cyc < 200) begin
                bus.flush = (flush_mid && cyc == 1);
                check("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
                prev_md = bus.mem_done;
                if (bus.mem_done) ndone++;
                @(negedge clk);
                cyc++;
            end
            bus.flush = 1'b0;
            check("miss_done_seen", 32'(bus.done), 32'd1);
            check("miss_busy_clear", 32'(bus.busy), 32'd0);
            check("miss_data", bus.read_data, exp);
            check("miss_word_count", 32'(ndone), 32'(WORDS));
            check("miss_done_after_last", 32'(prev_md), 32'd1);
            check("refill_len", 32'(addr_log.size() - log_start), 32'(WORDS));
            for (int i = 0; i < WORDS; i++) begin
                if (log_start + i < addr_log.size())
                    check("refill_addr", addr_log[log_start + i], base + 32'(4 * i));
            end
            m_valid[idx] = 1'b1;
            m_base[idx]  = base;
            if (flush_mid) model_flush();
        end

        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        if (exp_hit) check("hit_no_refill", 32'(addr_log.size() - log_start), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        int          cyc;
        logic [31:0] a;
        int          sel;

        bus.read_flag = 1'b0;
        bus.addr      = '0;
        bus.flush     = 1'b0;
        model_flush();
        for (int i = 0; i < LINES; i++) m_base[i] = '0;
        mem_over[32'h0000_0100] = 32'h11;
        mem_over[32'h0000_0104] = 32'h22;
        mem_over[32'h0000_0108] = 32'h33;
        mem_over[32'h0000_010C] = 32'h44;

        // Reset values, before any clock edge
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_read_data", bus.read_data, 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed scenarios, 2-cycle memory
        fixed_lat = 2;
        do_read(32'h0000_0100, 1'b0, 1'b0);   // cold miss -> 0x11
        do_read(32'h0000_0108, 1'b0, 1'b0);   // hit -> 0x33
        do_read(32'h0000_0200, 1'b0, 1'b0);   // conflict, index 0 tag 2
        do_read(32'h0000_0104, 1'b0, 1'b0);   // evicted again -> 0x22
        do_read(32'h0000_004C, 1'b0, 1'b0);   // offset 3 captured
        do_flush();
        do_read(32'h0000_0108, 1'b0, 1'b1);   // miss, flush pulsed mid-refill
        do_read(32'h0000_0108, 1'b0, 1'b0);   // must miss again
        do_read(32'h0000_0108, 1'b1, 1'b0);   // flush on request edge -> miss
        do_read(32'hFFFF_FFF4, 1'b0, 1'b0);   // top line, wraps to 0xFFFF_FFFC
        do_read(32'hFFFF_FFF8, 1'b0, 1'b0);   // hit on top line

        // Asynchronous reset after the 2nd refill word
        bus.read_flag = 1'b1;
        bus.addr      = 32'h0000_0500;
        @(negedge clk);
        bus.read_flag = 1'b0;
        check("arst_miss_busy", 32'(bus.busy), 32'd1);
        n   = 0;
        cyc = 0;
        while (n < 2 && cyc < 50) begin
            if (bus.mem_done) n++;
            @(negedge clk);
            cyc++;
        end
        check("arst_two_words", 32'(n), 32'd2);
        check("arst_mem_read_before", 32'(bus.mem_read), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_read", 32'(bus.mem_read), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_mem_addr", bus.mem_addr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_flush();
        @(negedge clk);
        stray_done = 1'b1;                    // mem_done with no request
        @(negedge clk);
        stray_done = 1'b0;
        check("stray_busy", 32'(bus.busy), 32'd0);
        check("stray_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("stray_idle_done", 32'(bus.done), 32'd0);
        do_read(32'h0000_0500, 1'b0, 1'b0);   // same line misses after reset
        do_read(32'h0000_0108, 1'b0, 1'b0);

        // Randomized traffic: few tags per index to mix hits and conflicts
        fixed_lat = 0;
        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 4));
            a   = $urandom & 32'h0000_00FC;
            if (sel == 4) a = a | 32'hFFFF_FF00;
            else          a = a | (32'(sel) << 8);
            if ($urandom_range(0, 14) == 0) do_flush();
            do_read(a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
